// File: rtl/score_keeper_pkg.sv
// Shared encodings and constants for the score keeper slice.
package score_keeper_pkg;

  typedef enum logic [1:0] {
    PLAY    = 2'd0,
    PENALTY = 2'd1,
    OVER    = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam int         BCD_W     = 4;

endpackage

// File: rtl/score_keeper_if.sv
// Game-event inputs and score/status/display outputs of the score keeper.
interface score_keeper_if;
  logic        correct_in;
  logic        incorrect_in;
  logic        new_game;
  logic [11:0] score_bcd;
  logic [11:0] high_bcd;
  logic [1:0]  lives;
  logic        game_over;
  logic        in_penalty;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

  modport master (
    output correct_in, incorrect_in, new_game,
    input  score_bcd, high_bcd, lives, game_over, in_penalty,
    input  hex0, hex1, hex2, hex3, hex4, hex5
  );

  modport slave (
    input  correct_in, incorrect_in, new_game,
    output score_bcd, high_bcd, lives, game_over, in_penalty,
    output hex0, hex1, hex2, hex3, hex4, hex5
  );
endinterface

// File: rtl/score_keeper_hex_decoder.sv
// BCD digit to active-low 7-segment pattern {g,f,e,d,c,b,a}; non-decimal codes blank.
module score_keeper_hex_decoder
  import score_keeper_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  output logic [6:0]       seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_keeper.sv
// Score, high score, lives and hit-streak bookkeeping with penalty window and game-over.
// state   | meaning
// PLAY    | normal play, hits score and misses cost a life
// PENALTY | misses ignored while the window counts down, hits still score
// OVER    | out of lives, waiting for a new_game edge
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int LIVES_INIT     = 3,
  parameter int MAX_LIVES      = 3,
  parameter int STREAK_LEN     = 10,
  parameter int PENALTY_CYCLES = 25000000
) (
  input  logic         clock,
  input  logic         resetn,
  score_keeper_if.slave sk
);

  localparam int SW = (STREAK_LEN > 1) ? $clog2(STREAK_LEN) : 1;
  localparam int PW = (PENALTY_CYCLES > 1) ? $clog2(PENALTY_CYCLES) : 1;
  localparam logic [1:0]    LIVES_RST   = 2'(LIVES_INIT);
  localparam logic [1:0]    LIVES_MAX   = 2'(MAX_LIVES);
  localparam logic [SW-1:0] STREAK_LAST = SW'(STREAK_LEN - 1);
  localparam logic [PW-1:0] PEN_LOAD    = PW'(PENALTY_CYCLES - 1);

  state_t        state;
  logic [SW-1:0] streak;
  logic [PW-1:0] pen_cnt;
  logic          correct_q, incorrect_q, new_game_q;
  logic [11:0]   score, high;
  logic [1:0]    lives;
  logic          game_over_r, in_penalty_r;

  logic          ev_correct, ev_incorrect, ev_new_game;
  logic [11:0]   score_next;
  logic [SW-1:0] streak_hit;
  logic [1:0]    lives_hit;

  assign ev_correct   = sk.correct_in   & ~correct_q;
  assign ev_incorrect = sk.incorrect_in & ~incorrect_q;
  assign ev_new_game  = sk.new_game     & ~new_game_q;

  // BCD increment with ripple carry, holding at 999
  always_comb begin
    score_next = score;
    if (score != 12'h999) begin
      if (score[3:0] != 4'd9) begin
        score_next[3:0] = score[3:0] + 4'd1;
      end else begin
        score_next[3:0] = 4'd0;
        if (score[7:4] != 4'd9) begin
          score_next[7:4] = score[7:4] + 4'd1;
        end else begin
          score_next[7:4]  = 4'd0;
          score_next[11:8] = score[11:8] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    streak_hit = streak + SW'(1);
    lives_hit  = lives;
    if (streak == STREAK_LAST) begin
      streak_hit = '0;
      if (lives < LIVES_MAX) lives_hit = lives + 2'd1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= PLAY;
      streak       <= '0;
      pen_cnt      <= '0;
      correct_q    <= 1'b0;
      incorrect_q  <= 1'b0;
      new_game_q   <= 1'b0;
      score        <= '0;
      high         <= '0;
      lives        <= LIVES_RST;
      game_over_r  <= 1'b0;
      in_penalty_r <= 1'b0;
    end else begin
      correct_q   <= sk.correct_in;
      incorrect_q <= sk.incorrect_in;
      new_game_q  <= sk.new_game;
      case (state)
        PLAY: begin
          if (ev_incorrect) begin
            streak <= '0;
            lives  <= lives - 2'd1;
            if (lives == 2'd1) begin
              state       <= OVER;
              game_over_r <= 1'b1;
              if (score > high) high <= score;
            end else begin
              state        <= PENALTY;
              in_penalty_r <= 1'b1;
              pen_cnt      <= PEN_LOAD;
            end
          end else if (ev_correct) begin
            score  <= score_next;
            streak <= streak_hit;
            lives  <= lives_hit;
          end
        end
        PENALTY: begin
          if (ev_correct) begin
            score  <= score_next;
            streak <= streak_hit;
            lives  <= lives_hit;
          end
          if (pen_cnt == '0) begin
            state        <= PLAY;
            in_penalty_r <= 1'b0;
          end else begin
            pen_cnt <= pen_cnt - PW'(1);
          end
        end
        OVER: begin
          if (ev_new_game) begin
            state       <= PLAY;
            score       <= '0;
            lives       <= LIVES_RST;
            streak      <= '0;
            game_over_r <= 1'b0;
          end
        end
        default: state <= PLAY;
      endcase
    end
  end

  assign sk.score_bcd  = score;
  assign sk.high_bcd   = high;
  assign sk.lives      = lives;
  assign sk.game_over  = game_over_r;
  assign sk.in_penalty = in_penalty_r;

  score_keeper_hex_decoder u_hex0 (.digit(score[BCD_W-1:0]),         .seg(sk.hex0));
  score_keeper_hex_decoder u_hex1 (.digit(score[2*BCD_W-1:BCD_W]),   .seg(sk.hex1));
  score_keeper_hex_decoder u_hex2 (.digit(score[3*BCD_W-1:2*BCD_W]), .seg(sk.hex2));
  score_keeper_hex_decoder u_hex3 (.digit(high[BCD_W-1:0]),          .seg(sk.hex3));
  score_keeper_hex_decoder u_hex4 (.digit(high[2*BCD_W-1:BCD_W]),    .seg(sk.hex4));
  score_keeper_hex_decoder u_hex5 (.digit(high[3*BCD_W-1:2*BCD_W]),  .seg(sk.hex5));

endmodule
